regfile_rename: RTL and testbench

- Parametrised architectural register file with per-register rename state (busy bit plus producer tag) for the out-of-order LC-3b core.
- Sits between decode/dispatch and the reorder buffer.
- Dispatch reads two sources and renames one destination per cycle. ROB commit writes retired results.
- A flush clears all pending renames on branch mispredict or exception.

---
 rtl/regfile_rename_if.sv | 34 +++
 rtl/regfile_rename.sv | 82 ++++++++
 tb/tb_regfile_rename.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/regfile_rename_if.sv
// regfile_rename_if: dispatch read/rename, ROB commit and flush bundle for the rename register file
interface regfile_rename_if #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_W      = 3,
    parameter int TAG_WIDTH  = 3
);
    logic [REG_W-1:0]      sr1;
    logic [REG_W-1:0]      sr2;
    logic [DATA_WIDTH-1:0] sr1_data;
    logic [DATA_WIDTH-1:0] sr2_data;
    logic                  sr1_busy;
    logic                  sr2_busy;
    logic [TAG_WIDTH-1:0]  sr1_tag;
    logic [TAG_WIDTH-1:0]  sr2_tag;
    logic                  rename_en;
    logic [REG_W-1:0]      rename_reg;
    logic [TAG_WIDTH-1:0]  rename_tag;
    logic                  commit_en;
    logic [REG_W-1:0]      commit_reg;
    logic [TAG_WIDTH-1:0]  commit_tag;
    logic [DATA_WIDTH-1:0] commit_data;
    logic                  flush;
    logic [REG_W:0]        busy_count;
    modport master (
        output sr1, sr2, rename_en, rename_reg, rename_tag,
               commit_en, commit_reg, commit_tag, commit_data, flush,
        input  sr1_data, sr2_data, sr1_busy, sr2_busy, sr1_tag, sr2_tag, busy_count
    );
    modport slave (
        input  sr1, sr2, rename_en, rename_reg, rename_tag,
               commit_en, commit_reg, commit_tag, commit_data, flush,
        output sr1_data, sr2_data, sr1_busy, sr2_busy, sr1_tag, sr2_tag, busy_count
    );
endinterface

// File: rtl/regfile_rename.sv
// regfile_rename: architectural register file with busy/tag rename state; REGFILE_COMMIT_BYPASS_EN adds commit-to-read forwarding
module regfile_rename #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 8,
    parameter int REG_W      = 3,
    parameter int TAG_WIDTH  = 3
) (
    input logic            clk,
    input logic            rst,
    regfile_rename_if.slave bus
);
    logic [DATA_WIDTH-1:0] data [NUM_REGS];
    logic [TAG_WIDTH-1:0]  tag [NUM_REGS];
    logic [TAG_WIDTH-1:0]  tag_n [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_n;
    logic [REG_W:0]        count_n;
    logic                  hit1;
    logic                  hit2;

`ifdef REGFILE_COMMIT_BYPASS_EN
    assign hit1 = bus.commit_en && bus.commit_reg == bus.sr1 && busy[bus.sr1] && tag[bus.sr1] == bus.commit_tag;
    assign hit2 = bus.commit_en && bus.commit_reg == bus.sr2 && busy[bus.sr2] && tag[bus.sr2] == bus.commit_tag;
`else
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif

    // Next rename state: commit clears the youngest producer, rename overrides it, flush overrides everything
    always_comb begin
        busy_n = busy;
        tag_n  = tag;
        if (bus.commit_en && busy[bus.commit_reg] && tag[bus.commit_reg] == bus.commit_tag)
            busy_n[bus.commit_reg] = 1'b0;
        if (bus.rename_en) begin
            busy_n[bus.rename_reg] = 1'b1;
            tag_n[bus.rename_reg]  = bus.rename_tag;
        end
        if (bus.flush) begin
            busy_n = '0;
            for (int i = 0; i < NUM_REGS; i++) tag_n[i] = '0;
        end
    end

    // Population count of the next busy vector, registered as busy_count
    always_comb begin
        count_n = '0;
        for (int i = 0; i < NUM_REGS; i++) count_n = count_n + (REG_W + 1)'(busy_n[i]);
    end

    // Rename state and busy counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy           <= '0;
            bus.busy_count <= '0;
            for (int i = 0; i < NUM_REGS; i++) tag[i] <= '0;
        end else begin
            busy           <= busy_n;
            tag            <= tag_n;
            bus.busy_count <= count_n;
        end
    end

    // Retired values are written regardless of rename state or flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) data[i] <= '0;
        end else if (bus.commit_en) begin
            data[bus.commit_reg] <= bus.commit_data;
        end
    end

    // Read ports from registered state, tag masked when not busy, optionally forwarding a matching commit
    always_comb begin
        bus.sr1_data = hit1 ? bus.commit_data : data[bus.sr1];
        bus.sr2_data = hit2 ? bus.commit_data : data[bus.sr2];
        bus.sr1_busy = busy[bus.sr1] && !hit1;
        bus.sr2_busy = busy[bus.sr2] && !hit2;
        bus.sr1_tag  = bus.sr1_busy ? tag[bus.sr1] : '0;
        bus.sr2_tag  = bus.sr2_busy ? tag[bus.sr2] : '0;
    end
endmodule

// File: tb/tb_regfile_rename.sv
// tb_regfile_rename: randomized and directed scoreboard bench for regfile_rename against an array-based reference model
module tb_regfile_rename;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    typedef struct {
        logic [15:0] d1, d2;
        logic        b1, b2;
        logic [2:0]  t1, t2;
        logic [3:0]  bc;
    } exp_t;

    exp_t        q[$];
    logic [15:0] m_data [8];
    logic [2:0]  m_tag  [8];
    logic [7:0]  m_busy;

    regfile_rename_if bus ();
    regfile_rename dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic fwd(input logic [2:0] s);
`ifdef REGFILE_COMMIT_BYPASS_EN
        return bus.commit_en && bus.commit_reg == s && m_busy[s] && m_tag[s] == bus.commit_tag;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_busy = '0;
        for (int i = 0; i < 8; i++) begin
            m_data[i] = '0;
            m_tag[i]  = '0;
        end
    endtask

    task automatic step(input logic [2:0] s1, input logic [2:0] s2,
                        input logic ren, input logic [2:0] rreg, input logic [2:0] rtag,
                        input logic cen, input logic [2:0] creg, input logic [2:0] ctag,
                        input logic [15:0] cdata, input logic fl);
        exp_t e;
        logic f1, f2;
        @(posedge clk);
        #1;
        bus.sr1 = s1; bus.sr2 = s2;
        bus.rename_en = ren; bus.rename_reg = rreg; bus.rename_tag = rtag;
        bus.commit_en = cen; bus.commit_reg = creg; bus.commit_tag = ctag; bus.commit_data = cdata;
        bus.flush = fl;
        f1 = fwd(s1);
        f2 = fwd(s2);
        e.d1 = f1 ? cdata : m_data[s1];
        e.d2 = f2 ? cdata : m_data[s2];
        e.b1 = m_busy[s1] && !f1;
        e.b2 = m_busy[s2] && !f2;
        e.t1 = e.b1 ? m_tag[s1] : 3'd0;
        e.t2 = e.b2 ? m_tag[s2] : 3'd0;
        e.bc = 4'($countones(m_busy));
        q.push_back(e);
        if (cen) begin
            m_data[creg] = cdata;
            if (m_busy[creg] && m_tag[creg] == ctag) m_busy[creg] = 1'b0;
        end
        if (ren) begin
            m_busy[rreg] = 1'b1;
            m_tag[rreg]  = rtag;
        end
        if (fl) begin
            m_busy = '0;
            for (int i = 0; i < 8; i++) m_tag[i] = '0;
        end
    endtask

    task automatic idle(input logic [2:0] s1, input logic [2:0] s2);
        step(s1, s2, 0, 0, 0, 0, 0, 0, 16'h0, 0);
    endtask

    // Monitor: every cycle's read outputs are compared with the queued expectation mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                n_vec++;
                if (bus.sr1_data !== e.d1 || bus.sr2_data !== e.d2 || bus.sr1_busy !== e.b1 ||
                    bus.sr2_busy !== e.b2 || bus.sr1_tag !== e.t1 || bus.sr2_tag !== e.t2 ||
                    bus.busy_count !== e.bc) begin
                    n_err++;
                    $display("FAIL reads t=%0t sr1=%0d sr2=%0d got d1=%h d2=%h b1=%b b2=%b t1=%0d t2=%0d bc=%0d exp d1=%h d2=%h b1=%b b2=%b t1=%0d t2=%0d bc=%0d",
                             $time, bus.sr1, bus.sr2, bus.sr1_data, bus.sr2_data, bus.sr1_busy, bus.sr2_busy,
                             bus.sr1_tag, bus.sr2_tag, bus.busy_count, e.d1, e.d2, e.b1, e.b2, e.t1, e.t2, e.bc);
                end
            end
        end
    end

    initial begin
        logic [2:0] cr;
        bus.sr1 = 0; bus.sr2 = 0;
        bus.rename_en = 0; bus.rename_reg = 0; bus.rename_tag = 0;
        bus.commit_en = 0; bus.commit_reg = 0; bus.commit_tag = 0; bus.commit_data = 0;
        bus.flush = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        idle(0, 1);
        // Rename then retire R3
        step(0, 0, 1, 3, 5, 0, 0, 0, 16'h0, 0);
        idle(3, 3);
        step(3, 0, 0, 0, 0, 1, 3, 5, 16'hBEEF, 0);
        idle(3, 0);
        // Stale commit leaves the younger producer pending
        step(0, 0, 1, 2, 1, 0, 0, 0, 16'h0, 0);
        step(2, 0, 1, 2, 4, 0, 0, 0, 16'h0, 0);
        step(2, 2, 0, 0, 0, 1, 2, 1, 16'h0011, 0);
        step(2, 0, 0, 0, 0, 1, 2, 4, 16'h0044, 0);
        idle(2, 2);
        // Same-cycle rename and commit on R6
        step(0, 0, 1, 6, 2, 0, 0, 0, 16'h0, 0);
        step(6, 6, 1, 6, 7, 1, 6, 2, 16'h1234, 0);
        idle(6, 6);
        // Flush beats rename, commit data still lands
        step(0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 1);
        for (int r = 0; r < 5; r++) step(3'(r), 0, 1, 3'(r), 3'(r + 1), 0, 0, 0, 16'h0, 0);
        step(1, 5, 1, 5, 3, 1, 1, 2, 16'hA5A5, 1);
        idle(1, 5);
        // Commit forwarding candidate on sr2
        step(0, 0, 1, 4, 6, 0, 0, 0, 16'h0, 0);
        step(0, 4, 0, 0, 0, 1, 4, 6, 16'h0F0F, 0);
        idle(0, 4);
        // Randomized traffic, commit tags biased toward the live producer
        for (int i = 0; i < 3000; i++) begin
            cr = 3'($urandom_range(0, 7));
            step(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), cr,
                 ($urandom_range(0, 3) != 0) ? m_tag[cr] : 3'($urandom_range(0, 7)),
                 16'($urandom), $urandom_range(0, 31) == 0);
        end
        // Fill every register with nonzero data and leave some busy before the async reset
        for (int r = 0; r < 8; r++) step(0, 0, 1, 3'(r), 3'(7 - r), 1, 3'(r), 3'd0, 16'(16'h1111 * (r + 1)), 0);
        @(negedge clk);
        bus.rename_en = 0; bus.commit_en = 0; bus.flush = 0;
        #2 rst = 1'b1;
        model_reset();
        for (int r = 0; r < 8; r++) begin
            bus.sr1 = 3'(r);
            bus.sr2 = 3'(7 - r);
            #1;
            n_vec++;
            if (bus.sr1_data !== 16'h0 || bus.sr2_data !== 16'h0 || bus.sr1_busy !== 1'b0 || bus.sr2_busy !== 1'b0 ||
                bus.sr1_tag !== 3'd0 || bus.sr2_tag !== 3'd0 || bus.busy_count !== 4'd0) begin
                n_err++;
                $display("FAIL async_reset r=%0d got d1=%h d2=%h b1=%b b2=%b t1=%0d t2=%0d bc=%0d exp all zero",
                         r, bus.sr1_data, bus.sr2_data, bus.sr1_busy, bus.sr2_busy, bus.sr1_tag, bus.sr2_tag, bus.busy_count);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            cr = 3'($urandom_range(0, 7));
            step(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), cr, m_tag[cr], 16'($urandom), $urandom_range(0, 31) == 0);
        end
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
